// File: rtl/emergency_pkg.sv
// Shared types and helpers for the emergency-vehicle preemption controller.
package emergency_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, SERVE, RECOVER} state_t;

  localparam int DEF_CLEAR_TIME = 2;
  localparam int DEF_HOLD_TIME  = 5;
  localparam int DEF_MAX_HOLD   = 20;
  localparam int MASK_W         = 64;

  // All lanes of one direction; callers size-cast down to their lane count.
  function automatic logic [MASK_W-1:0] lane_mask(input int dir, input int lanes_per_dir);
    logic [MASK_W-1:0] ones;
    ones = (MASK_W'(1) << lanes_per_dir) - MASK_W'(1);
    return ones << (dir * lanes_per_dir);
  endfunction

endpackage

// File: rtl/emergency_preempt_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping. Purely combinational.
module emergency_preempt_rr_arbiter #(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = 2
) (
  input  logic [NUM_DIR-1:0] req,
  input  logic [DIR_W-1:0]   ptr,
  output logic [NUM_DIR-1:0] gnt,
  output logic [DIR_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (!gnt_vld && req[(int'(ptr) + i) % NUM_DIR]) begin
        gnt_vld = 1'b1;
        gnt_idx = DIR_W'((int'(ptr) + i) % NUM_DIR);
      end
    end
    gnt = gnt_vld ? (NUM_DIR'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/emergency_preempt.sv
// Emergency preemption controller: latches lane requests, arbitrates directions
// round-robin, and runs clearance -> timed green hold -> recovery.
module emergency_preempt
  import emergency_pkg::*;
#(
  parameter int NUM_DIR       = 4,
  parameter int LANES_PER_DIR = 2,
  parameter int TIME_W        = 7,
  parameter int CLEAR_TIME    = DEF_CLEAR_TIME,
  parameter int HOLD_TIME     = DEF_HOLD_TIME,
  parameter int MAX_HOLD      = DEF_MAX_HOLD,
  localparam int NUM_LANES    = NUM_DIR * LANES_PER_DIR,
  localparam int DIR_W        = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] emergency_lane,
  output logic [NUM_LANES-1:0] lane_output,
  output logic                 all_red,
  output logic                 emergency_active,
  output logic [DIR_W-1:0]     preempt_dir,
  output logic                 load_command,
  output logic [TIME_W-1:0]    load_time,
  output logic                 normal_resume
);

  localparam logic [TIME_W-1:0] CT  = TIME_W'(CLEAR_TIME);
  localparam logic [TIME_W-1:0] HT  = TIME_W'(HOLD_TIME);
  localparam logic [TIME_W-1:0] MH  = TIME_W'(MAX_HOLD);
  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  if (NUM_DIR < 1 || LANES_PER_DIR < 1 || NUM_LANES > MASK_W || CLEAR_TIME < 1 ||
      HOLD_TIME < 1 || MAX_HOLD < HOLD_TIME || MAX_HOLD >= 2**TIME_W ||
      CLEAR_TIME >= 2**TIME_W) begin : g_bad_params
    $error("emergency_preempt: illegal parameter set");
  end

  state_t               state;
  logic [TIME_W-1:0]    cnt, hold_cnt, tot_cnt;
  logic [NUM_DIR-1:0]   pending, dir_req, req_all, gnt, others;
  logic [DIR_W-1:0]     rr_ptr, gnt_idx, rr_next;
  logic                 gnt_vld, extend;
  logic [NUM_LANES-1:0] gnt_mask;

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    assign dir_req[d] = |emergency_lane[d*LANES_PER_DIR +: LANES_PER_DIR];
  end

  // Same-cycle requests count, so a request never waits on its own latch.
  assign req_all  = pending | dir_req;
  assign others   = req_all & ~(NUM_DIR'(1) << preempt_dir);
  assign extend   = dir_req[preempt_dir] && (tot_cnt < MH);
  assign rr_next  = (gnt_idx == DIR_W'(NUM_DIR - 1)) ? '0 : gnt_idx + DIR_W'(1);
  assign gnt_mask = NUM_LANES'(lane_mask(int'(gnt_idx), LANES_PER_DIR));

  emergency_preempt_rr_arbiter #(.NUM_DIR(NUM_DIR), .DIR_W(DIR_W)) u_arb (
    .req     (req_all),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pending          <= '0;
      rr_ptr           <= '0;
      cnt              <= '0;
      hold_cnt         <= '0;
      tot_cnt          <= '0;
      lane_output      <= '0;
      all_red          <= 1'b0;
      emergency_active <= 1'b0;
      preempt_dir      <= '0;
      load_command     <= 1'b0;
      load_time        <= '0;
      normal_resume    <= 1'b0;
    end else begin
      load_command  <= 1'b0;
      load_time     <= '0;
      normal_resume <= 1'b0;
      pending       <= req_all;
      case (state)
        IDLE: if (|req_all) begin
          state            <= CLEAR;
          cnt              <= CT;
          all_red          <= 1'b1;
          emergency_active <= 1'b1;
        end
        CLEAR: if (cnt != ONE) begin
          cnt <= cnt - ONE;
        end else if (gnt_vld) begin
          // Granted direction's latch clears even if it is still requesting.
          state        <= SERVE;
          pending      <= req_all & ~gnt;
          rr_ptr       <= rr_next;
          preempt_dir  <= gnt_idx;
          lane_output  <= gnt_mask;
          all_red      <= 1'b0;
          load_command <= 1'b1;
          load_time    <= HT;
          hold_cnt     <= HT;
          tot_cnt      <= ONE;
        end else begin
          state            <= IDLE;
          all_red          <= 1'b0;
          emergency_active <= 1'b0;
        end
        SERVE: if (hold_cnt == ONE && extend) begin
          hold_cnt <= HT;
          tot_cnt  <= tot_cnt + ONE;
        end else if (hold_cnt == ONE || tot_cnt == MH) begin
          lane_output <= '0;
          all_red     <= 1'b1;
          cnt         <= CT;
          if (|others) state <= CLEAR;
          else begin
            state         <= RECOVER;
            normal_resume <= (CT == ONE) && !(|req_all);
          end
        end else begin
          hold_cnt <= hold_cnt - ONE;
          tot_cnt  <= tot_cnt + ONE;
        end
        RECOVER: if (cnt == ONE) begin
          // Resume was committed on entry to this last cycle; otherwise re-clear.
          cnt <= CT;
          if (normal_resume) begin
            state            <= IDLE;
            all_red          <= 1'b0;
            emergency_active <= 1'b0;
          end else state <= CLEAR;
        end else begin
          cnt           <= cnt - ONE;
          normal_resume <= (cnt == TIME_W'(2)) && !(|req_all);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emergency_preempt.sv
// Directed bench for emergency_preempt (default parameters, 4 dirs x 2 lanes).
module tb_emergency_preempt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] emergency_lane = '0;
  logic [7:0] lane_output;
  logic       all_red, emergency_active, load_command, normal_resume;
  logic [1:0] preempt_dir;
  logic [6:0] load_time;

  int n_cmp = 0;
  int n_bad = 0;

  emergency_preempt dut (
    .clk              (clk),
    .rst              (rst),
    .emergency_lane   (emergency_lane),
    .lane_output      (lane_output),
    .all_red          (all_red),
    .emergency_active (emergency_active),
    .preempt_dir      (preempt_dir),
    .load_command     (load_command),
    .load_time        (load_time),
    .normal_resume    (normal_resume)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_v();
    return {20'b0, lane_output, all_red, emergency_active, load_command, normal_resume};
  endfunction

  function automatic logic [31:0] ev(input logic [7:0] l, input logic r, input logic a,
                                     input logic ld, input logic rs);
    return {20'b0, l, r, a, ld, rs};
  endfunction

  function automatic logic is_dir_mask(input logic [7:0] l);
    logic [7:0] m;
    for (int d = 0; d < 4; d++) begin
      m = 8'h03 << (2 * d);
      if (l == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Advance until load_command; w = cycles advanced, res = resume pulses seen on the way.
  task automatic wait_load(input int budget, output int w, output int res);
    w = 0;
    res = 0;
    do begin
      tick();
      w++;
      res += int'(normal_resume);
    end while (!load_command && w < budget);
    chk("load_seen", 32'(load_command), 32'd1);
  endtask

  task automatic wait_resume(input int budget, output int w);
    w = 0;
    do begin
      tick();
      w++;
    end while (!normal_resume && w < budget);
    chk("resume_seen", 32'(normal_resume), 32'd1);
  endtask

  initial begin
    int w, res, g, loads, entries;
    logic on, prev_on;

    // reset state
    tick();
    rst_pulse();
    chk("reset_out", obs_v(), 32'd0);
    chk("reset_dir", 32'(preempt_dir), 32'd0);
    chk("reset_ltime", 32'(load_time), 32'd0);

    // 1: single-cycle pulse on lane 2 -> dir 1 (lanes 2,3)
    emergency_lane = 8'h04;
    tick();
    emergency_lane = 8'h00;
    chk("t1_clear1", obs_v(), ev(8'h00, 1, 1, 0, 0));
    tick();
    chk("t1_clear2", obs_v(), ev(8'h00, 1, 1, 0, 0));
    tick();
    chk("t1_load", obs_v(), ev(8'h0C, 0, 1, 1, 0));
    chk("t1_ltime", 32'(load_time), 32'd5);
    chk("t1_dir", 32'(preempt_dir), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_hold", obs_v(), ev(8'h0C, 0, 1, 0, 0));
    end
    tick();
    chk("t1_rec1", obs_v(), ev(8'h00, 1, 1, 0, 0));
    tick();
    chk("t1_rec2", obs_v(), ev(8'h00, 1, 1, 0, 1));
    tick();
    chk("t1_idle", obs_v(), 32'd0);

    // 2: lanes 0 and 6 together -> dir 0 then dir 3, one resume at the end
    rst_pulse();
    emergency_lane = 8'h41;
    tick();
    emergency_lane = 8'h00;
    wait_load(10, w, res);
    chk("t2_lat0", 32'(w), 32'd2);
    chk("t2_dir0", 32'(preempt_dir), 32'd0);
    chk("t2_lane0", 32'(lane_output), 32'h03);
    wait_load(20, w, res);
    chk("t2_gap", 32'(w), 32'd7);
    chk("t2_nores", 32'(res), 32'd0);
    chk("t2_dir3", 32'(preempt_dir), 32'd3);
    chk("t2_lane3", 32'(lane_output), 32'hC0);
    wait_resume(20, w);
    chk("t2_res_lat", 32'(w), 32'd6);
    res = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      res += int'(normal_resume);
    end
    chk("t2_one_res", 32'(res), 32'd0);
    chk("t2_idle", obs_v(), 32'd0);

    // 3: dir 2 held -> green capped at 20, recover/clear, re-served; dir 3 not starved
    rst_pulse();
    emergency_lane = 8'h10;
    tick();
    wait_load(10, w, res);
    chk("t3_dir2", 32'(preempt_dir), 32'd2);
    g = 0;
    while (lane_output != 8'h00 && g < 40) begin
      g++;
      tick();
    end
    chk("t3_green_len", 32'(g), 32'd20);
    for (int i = 0; i < 4; i++) begin
      chk("t3_allred", obs_v(), ev(8'h00, 1, 1, 0, 0));
      tick();
    end
    chk("t3_reserve", obs_v(), ev(8'h30, 0, 1, 1, 0));
    emergency_lane = 8'h50;
    wait_load(40, w, res);
    chk("t3_gap_d3", 32'(w), 32'd22);
    chk("t3_dir3", 32'(preempt_dir), 32'd3);
    wait_load(40, w, res);
    chk("t3_gap_d2", 32'(w), 32'd22);
    chk("t3_back_d2", 32'(preempt_dir), 32'd2);
    chk("t3_nores", 32'(res), 32'd0);

    // 5: reset mid-SERVE clears outputs and pending
    rst = 1'b1;
    emergency_lane = 8'h00;
    tick();
    chk("t5_rst_out", obs_v(), 32'd0);
    chk("t5_rst_dir", 32'(preempt_dir), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stay_idle", obs_v(), 32'd0);
    end
    emergency_lane = 8'h80;
    tick();
    emergency_lane = 8'h00;
    chk("t5_clear", obs_v(), ev(8'h00, 1, 1, 0, 0));
    wait_load(10, w, res);
    chk("t5_lat", 32'(w), 32'd2);
    chk("t5_dir3", 32'(preempt_dir), 32'd3);

    // 4: all directions held -> grant order 0,1,2,3,0
    rst_pulse();
    emergency_lane = 8'hAA;
    tick();
    for (int i = 0; i < 5; i++) begin
      wait_load(40, w, res);
      chk("t4_gap", 32'(w), (i == 0) ? 32'd2 : 32'd22);
      chk("t4_order", 32'(preempt_dir), 32'(i % 4));
    end
    emergency_lane = 8'h00;

    // 6: sparse random lane stimulus, safety invariants every cycle
    rst_pulse();
    loads = 0;
    entries = 0;
    prev_on = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 8; b++) emergency_lane[b] = ($urandom_range(0, 15) == 0);
      tick();
      on = (lane_output != 8'h00);
      if (on) begin
        chk("inv_one_dir", 32'(is_dir_mask(lane_output)), 32'd1);
        chk("inv_red_excl", 32'(all_red), 32'd0);
      end
      chk("inv_load_entry", 32'(load_command), 32'(on && !prev_on));
      chk("inv_ltime", 32'(load_time), load_command ? 32'd5 : 32'd0);
      loads += int'(load_command);
      entries += int'(on && !prev_on);
      prev_on = on;
    end
    emergency_lane = 8'h00;
    chk("rand_load_count", 32'(loads), 32'(entries));
    chk("rand_activity", 32'(loads > 10), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
